cond_unit_vp: RTL and testbench

//  Execute-stage condition unit, parametrised successor of the scalar unit.
//  - Holds one scalar NZCV register and LANES per-lane vector NZCV registers.
//  - Evaluates ARM condition codes for scalar and vector instructions and gates

---
 rtl/cond_unit_vp_if.sv | 57 +++++
 rtl/cond_unit_vp.sv | 137 +++++++++++++
 tb/tb_cond_unit_vp.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_unit_vp_if.sv
// Execute-stage bundle for the condition unit: instruction controls in,
// gated strobes and flag/predication state out.
interface cond_unit_vp_if #(
  parameter int LANES  = 4,
  parameter int IT_MAX = 4
);
  localparam int CNT_W = $clog2(IT_MAX + 1);

  logic                 stall;
  logic                 flush;
  logic                 ValidE;
  logic [3:0]           CondE;
  logic [1:0]           FlagWriteE;
  logic [3:0]           ALUFlagsE;
  logic                 BranchE;
  logic                 PCSrcE;
  logic                 RegWriteE;
  logic                 MemWriteE;
  logic                 linkE;
  logic                 NoWrite;
  logic                 VecE;
  logic [4*LANES-1:0]   ALUFlagsVE;
  logic                 FlagWriteVE;
  logic                 RegWriteVE;
  logic                 MemWriteVE;
  logic                 ItStartE;
  logic [CNT_W-1:0]     ItLenE;
  logic [IT_MAX-1:0]    ItMaskE;

  logic [3:0]           Flags;
  logic [4*LANES-1:0]   FlagsV;
  logic                 RegWrite;
  logic                 MemWrite;
  logic                 PCSrc;
  logic                 link;
  logic                 BranchTakenE;
  logic [LANES-1:0]     LaneEnV;
  logic [LANES-1:0]     MemWriteV;
  logic                 ItActive;
  logic [CNT_W-1:0]     ItCount;

  modport master (
    output stall, flush, ValidE, CondE, FlagWriteE, ALUFlagsE, BranchE, PCSrcE,
           RegWriteE, MemWriteE, linkE, NoWrite, VecE, ALUFlagsVE, FlagWriteVE,
           RegWriteVE, MemWriteVE, ItStartE, ItLenE, ItMaskE,
    input  Flags, FlagsV, RegWrite, MemWrite, PCSrc, link, BranchTakenE,
           LaneEnV, MemWriteV, ItActive, ItCount
  );

  modport slave (
    input  stall, flush, ValidE, CondE, FlagWriteE, ALUFlagsE, BranchE, PCSrcE,
           RegWriteE, MemWriteE, linkE, NoWrite, VecE, ALUFlagsVE, FlagWriteVE,
           RegWriteVE, MemWriteVE, ItStartE, ItLenE, ItMaskE,
    output Flags, FlagsV, RegWrite, MemWrite, PCSrc, link, BranchTakenE,
           LaneEnV, MemWriteV, ItActive, ItCount
  );
endinterface

// File: rtl/cond_unit_vp.sv
// Execute-stage condition unit: scalar + per-lane NZCV registers, ARM condition
// evaluation, strobe gating and IT-style predicated blocks.
module cond_unit_vp #(
  parameter int LANES  = 4,
  parameter int IT_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  cond_unit_vp_if.slave bus
);
  localparam int CNT_W = $clog2(IT_MAX + 1);

  typedef enum logic {IT_IDLE, IT_ACTIVE} it_state_e;

  it_state_e          state_q, state_d;
  logic [3:0]         flags_q, flags_d;
  logic [4*LANES-1:0] flags_v_q, flags_v_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [3:0]         base_q, base_d;
  logic [IT_MAX-1:0]  mask_q, mask_d;

  // Flag layout is {N,Z,C,V} from bit 3 down to bit 0.
  function automatic logic cond_pass(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'b0000: return z;
      4'b0001: return ~z;
      4'b0010: return c;
      4'b0011: return ~c;
      4'b0100: return n;
      4'b0101: return ~n;
      4'b0110: return v;
      4'b0111: return ~v;
      4'b1000: return c & ~z;
      4'b1001: return ~c | z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return ~z & (n == v);
      4'b1101: return z | (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic              accept, exec, out_en, len_ok, then_slot, cond_ex, pc_src;
  logic [CNT_W-1:0]  slot;
  logic [3:0]        code;
  logic [LANES-1:0]  lane_ex, lane_en, lane_mw;

  assign accept = bus.ValidE & ~bus.stall & ~bus.flush;
  // Headers (valid, malformed or nested) never write anything.
  assign exec   = accept & ~bus.ItStartE;
  assign out_en = exec & reset;
  assign len_ok = (bus.ItLenE != '0) && (bus.ItLenE <= CNT_W'(IT_MAX));

  assign slot      = len_q - cnt_q;
  assign then_slot = |(mask_q & ({{(IT_MAX-1){1'b0}}, 1'b1} << slot));
  assign code      = (state_q == IT_ACTIVE) ? {base_q[3:1], base_q[0] ^ ~then_slot}
                                            : bus.CondE;
  assign cond_ex   = cond_pass(code, flags_q);
  assign pc_src    = exec & (bus.PCSrcE | bus.BranchE) & cond_ex;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_ex[gi] = bus.VecE & cond_pass(code, flags_v_q[4*gi +: 4]);
      assign lane_en[gi] = out_en & bus.RegWriteVE & lane_ex[gi];
      assign lane_mw[gi] = out_en & bus.MemWriteVE & lane_ex[gi];
    end
  endgenerate

  assign bus.RegWrite     = out_en & bus.RegWriteE & cond_ex & ~bus.NoWrite;
  assign bus.MemWrite     = out_en & bus.MemWriteE & cond_ex;
  assign bus.PCSrc        = pc_src & reset;
  assign bus.BranchTakenE = out_en & bus.BranchE & cond_ex;
  assign bus.link         = out_en & bus.linkE & cond_ex;
  assign bus.LaneEnV      = lane_en;
  assign bus.MemWriteV    = lane_mw;
  assign bus.Flags        = flags_q;
  assign bus.FlagsV       = flags_v_q;
  assign bus.ItCount      = cnt_q;
  assign bus.ItActive     = (state_q == IT_ACTIVE);

  always_comb begin
    flags_d   = flags_q;
    flags_v_d = flags_v_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    base_d    = base_q;
    mask_d    = mask_q;

    if (exec) begin
      if (bus.FlagWriteE[1] & cond_ex) flags_d[3:2] = bus.ALUFlagsE[3:2];
      if (bus.FlagWriteE[0] & cond_ex) flags_d[1:0] = bus.ALUFlagsE[1:0];
      for (int i = 0; i < LANES; i++) begin
        if (bus.FlagWriteVE & lane_ex[i]) flags_v_d[4*i +: 4] = bus.ALUFlagsVE[4*i +: 4];
      end
    end

    // Flush wins over stall so a held stage can still drop its block.
    if (bus.flush) begin
      cnt_d = '0;
    end else if (accept) begin
      if (state_q == IT_ACTIVE) begin
        cnt_d = pc_src ? '0 : cnt_q - CNT_W'(1);
      end else if (bus.ItStartE && len_ok) begin
        cnt_d  = bus.ItLenE;
        len_d  = bus.ItLenE;
        base_d = bus.CondE;
        mask_d = bus.ItMaskE;
      end
    end

    state_d = (cnt_d != '0) ? IT_ACTIVE : IT_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IT_IDLE;
      flags_q   <= '0;
      flags_v_q <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      base_q    <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      flags_v_q <= flags_v_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      base_q    <= base_d;
      mask_q    <= mask_d;
    end
  end
endmodule

// File: tb/tb_cond_unit_vp.sv
// Self-checking bench for cond_unit_vp: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_cond_unit_vp;
  localparam int LANES  = 4;
  localparam int IT_MAX = 4;
  localparam int CNT_W  = $clog2(IT_MAX + 1);

  localparam logic [3:0] C_EQ = 4'b0000, C_NE = 4'b0001, C_AL = 4'b1110, C_NV = 4'b1111;

  logic clk;
  logic reset;

  cond_unit_vp_if #(.LANES(LANES), .IT_MAX(IT_MAX)) bus ();

  cond_unit_vp #(.LANES(LANES), .IT_MAX(IT_MAX)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the open block is a queue of the codes still to be used.
  bit [3:0] m_flags;
  bit [3:0] m_lanes [LANES];
  bit [3:0] m_codes [$];

  // ARM pairs: bits [3:1] select a base test, bit 0 inverts it (AL inverted is never).
  function automatic bit cpass(input bit [3:0] code, input bit [3:0] f);
    bit n = f[3];
    bit z = f[2];
    bit c = f[1];
    bit v = f[0];
    bit r;
    case (code[3:1])
      3'd0:    r = z;
      3'd1:    r = c;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = c && !z;
      3'd5:    r = (n == v);
      3'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return r ^ code[0];
  endfunction

  task automatic model_reset();
    m_flags = '0;
    for (int i = 0; i < LANES; i++) m_lanes[i] = '0;
    m_codes.delete();
  endtask

  bit             p_acc, p_hdr, p_ex, p_pc;
  bit [LANES-1:0] p_lane;
  logic [12:0]    samp_strobes;

  task automatic clear_inputs();
    bus.stall = 0; bus.flush = 0; bus.ValidE = 1; bus.CondE = C_AL;
    bus.FlagWriteE = 0; bus.ALUFlagsE = 0; bus.BranchE = 0; bus.PCSrcE = 0;
    bus.RegWriteE = 0; bus.MemWriteE = 0; bus.linkE = 0; bus.NoWrite = 0;
    bus.VecE = 0; bus.ALUFlagsVE = 0; bus.FlagWriteVE = 0; bus.RegWriteVE = 0;
    bus.MemWriteVE = 0; bus.ItStartE = 0; bus.ItLenE = 0; bus.ItMaskE = 0;
  endtask

  function automatic logic [12:0] act_strobes();
    return {bus.RegWrite, bus.MemWrite, bus.PCSrc, bus.link, bus.BranchTakenE,
            bus.LaneEnV, bus.MemWriteV};
  endfunction

  function automatic logic [4*LANES-1:0] model_flagsv();
    logic [4*LANES-1:0] r;
    for (int i = 0; i < LANES; i++) r[4*i +: 4] = m_lanes[i];
    return r;
  endfunction

  // Inputs are already driven; check strobes, clock once, check state.
  task automatic step();
    bit [3:0]       code;
    bit [LANES-1:0] e_lane_en, e_lane_mw;
    bit             e_rw, e_mw, e_link, e_bt;
    #1;
    p_acc = bus.ValidE && !bus.stall && !bus.flush;
    p_hdr = bus.ItStartE;
    code  = (m_codes.size() != 0) ? m_codes[0] : bus.CondE;
    p_ex  = p_acc && !p_hdr && cpass(code, m_flags);
    for (int i = 0; i < LANES; i++) begin
      p_lane[i]    = p_acc && !p_hdr && bus.VecE && cpass(code, m_lanes[i]);
      e_lane_en[i] = p_lane[i] && bus.RegWriteVE;
      e_lane_mw[i] = p_lane[i] && bus.MemWriteVE;
    end
    e_rw   = p_ex && bus.RegWriteE && !bus.NoWrite;
    e_mw   = p_ex && bus.MemWriteE;
    p_pc   = p_ex && (bus.PCSrcE || bus.BranchE);
    e_link = p_ex && bus.linkE;
    e_bt   = p_ex && bus.BranchE;
    samp_strobes = act_strobes();
    chk("strobes", 64'(samp_strobes),
        64'({e_rw, e_mw, p_pc, e_link, e_bt, e_lane_en, e_lane_mw}));

    @(posedge clk);
    if (p_ex) begin
      if (bus.FlagWriteE[1]) m_flags[3:2] = bus.ALUFlagsE[3:2];
      if (bus.FlagWriteE[0]) m_flags[1:0] = bus.ALUFlagsE[1:0];
    end
    for (int i = 0; i < LANES; i++)
      if (p_lane[i] && bus.FlagWriteVE) m_lanes[i] = bus.ALUFlagsVE[4*i +: 4];
    if (bus.flush) begin
      m_codes.delete();
    end else if (p_acc) begin
      if (m_codes.size() != 0) begin
        void'(m_codes.pop_front());
        if (p_pc) m_codes.delete();
      end else if (p_hdr && bus.ItLenE >= 1 && int'(bus.ItLenE) <= IT_MAX) begin
        for (int k = 0; k < int'(bus.ItLenE); k++)
          m_codes.push_back(bus.ItMaskE[k] ? bus.CondE : (bus.CondE ^ 4'd1));
      end
    end
    #1;
    chk("flags",     64'(bus.Flags),    64'(m_flags));
    chk("flagsv",    64'(bus.FlagsV),   64'(model_flagsv()));
    chk("it_count",  64'(bus.ItCount),  64'(m_codes.size()));
    chk("it_active", 64'(bus.ItActive), 64'(m_codes.size() != 0));
  endtask

  typedef struct {
    logic                vec;
    logic [3:0]          cond;
    logic [1:0]          fw;
    logic [3:0]          alu;
    logic                regw;
    logic                fwv;
    logic [4*LANES-1:0]  aluv;
    logic                regwv;
    logic                its;
    logic [CNT_W-1:0]    itlen;
    logic [IT_MAX-1:0]   itmask;
    logic                e_regw;
    logic [LANES-1:0]    e_lane;
    logic [CNT_W-1:0]    e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic vec, input logic [3:0] cond, input logic [1:0] fw,
                              input logic [3:0] alu, input logic regw, input logic fwv,
                              input logic [15:0] aluv, input logic regwv, input logic its,
                              input logic [2:0] itlen, input logic [3:0] itmask,
                              input logic e_regw, input logic [3:0] e_lane,
                              input logic [2:0] e_cnt);
    vec_t v;
    v.vec = vec; v.cond = cond; v.fw = fw; v.alu = alu; v.regw = regw; v.fwv = fwv;
    v.aluv = aluv; v.regwv = regwv; v.its = its; v.itlen = itlen; v.itmask = itmask;
    v.e_regw = e_regw; v.e_lane = e_lane; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // One row per cycle, applied in order from reset.
    tbl[0]  = mk(0, C_EQ, 2'b00, 4'b0000, 1, 0, 16'h0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0);
    tbl[1]  = mk(0, C_AL, 2'b11, 4'b0100, 0, 0, 16'h0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0);
    tbl[2]  = mk(0, C_EQ, 2'b00, 4'b0000, 1, 0, 16'h0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 0);
    tbl[3]  = mk(1, C_AL, 2'b00, 4'b0000, 0, 1, 16'h0404, 0, 0, 0, 4'b0000, 0, 4'b0000, 0);
    tbl[4]  = mk(1, C_EQ, 2'b00, 4'b0000, 0, 0, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0101, 0);
    tbl[5]  = mk(1, C_NE, 2'b00, 4'b0000, 0, 0, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b1010, 0);
    tbl[6]  = mk(0, C_EQ, 2'b00, 4'b0000, 1, 0, 16'h0000, 0, 1, 3, 4'b0101, 0, 4'b0000, 3);
    tbl[7]  = mk(0, C_NE, 2'b00, 4'b0000, 1, 0, 16'h0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 2);
    tbl[8]  = mk(0, C_NE, 2'b00, 4'b0000, 1, 0, 16'h0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 1);
    tbl[9]  = mk(0, C_NE, 2'b00, 4'b0000, 1, 0, 16'h0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 0);
    tbl[10] = mk(0, C_AL, 2'b00, 4'b0000, 1, 0, 16'h0000, 0, 1, 0, 4'b1111, 0, 4'b0000, 0);
    tbl[11] = mk(0, C_AL, 2'b00, 4'b0000, 1, 0, 16'h0000, 0, 1, 5, 4'b1111, 0, 4'b0000, 0);
    tbl[12] = mk(0, C_AL, 2'b00, 4'b0000, 1, 0, 16'h0000, 0, 1, 2, 4'b0001, 0, 4'b0000, 2);
    tbl[13] = mk(0, C_NV, 2'b00, 4'b0000, 1, 0, 16'h0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 1);
    tbl[14] = mk(0, C_AL, 2'b00, 4'b0000, 1, 0, 16'h0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0);

    clear_inputs();
    bus.RegWriteE = 1;
    reset = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_regwrite", 64'(bus.RegWrite), 64'(0));
    chk("reset_flags",    64'(bus.Flags),    64'(0));
    chk("reset_flagsv",   64'(bus.FlagsV),   64'(0));
    chk("reset_count",    64'(bus.ItCount),  64'(0));
    chk("reset_active",   64'(bus.ItActive), 64'(0));
    reset = 1;

    for (int r = 0; r < 15; r++) begin
      clear_inputs();
      bus.VecE = tbl[r].vec; bus.CondE = tbl[r].cond; bus.FlagWriteE = tbl[r].fw;
      bus.ALUFlagsE = tbl[r].alu; bus.RegWriteE = tbl[r].regw; bus.FlagWriteVE = tbl[r].fwv;
      bus.ALUFlagsVE = tbl[r].aluv; bus.RegWriteVE = tbl[r].regwv; bus.ItStartE = tbl[r].its;
      bus.ItLenE = tbl[r].itlen; bus.ItMaskE = tbl[r].itmask;
      step();
      chk($sformatf("row%0d_regwrite", r), 64'(samp_strobes[12]), 64'(tbl[r].e_regw));
      chk($sformatf("row%0d_laneen", r),   64'(samp_strobes[7:4]), 64'(tbl[r].e_lane));
      chk($sformatf("row%0d_count", r),    64'(bus.ItCount),      64'(tbl[r].e_cnt));
      $display("row %0d cond=%b its=%0b regw=%0b lane=%b cnt=%0d", r, tbl[r].cond,
               tbl[r].its, samp_strobes[12], samp_strobes[7:4], bus.ItCount);
    end

    // Taken branch in slot 1 closes the block; the next instruction uses CondE.
    clear_inputs(); bus.ItStartE = 1; bus.CondE = C_EQ; bus.ItLenE = 3; bus.ItMaskE = 4'b0111;
    step();
    chk("br_hdr_count", 64'(bus.ItCount), 64'(3));
    clear_inputs(); bus.RegWriteE = 1; bus.CondE = C_NE;
    step();
    chk("br_slot0_regwrite", 64'(samp_strobes[12]), 64'(1));
    clear_inputs(); bus.BranchE = 1;
    step();
    chk("br_taken", 64'(samp_strobes[8]), 64'(1));
    chk("br_count", 64'(bus.ItCount), 64'(0));
    clear_inputs(); bus.RegWriteE = 1; bus.CondE = C_NE;
    step();
    chk("br_after_regwrite", 64'(samp_strobes[12]), 64'(0));
    $display("branch seq taken-branch closes block, count=%0d", bus.ItCount);

    // Stall holds everything with strobes low; flush then drops the block.
    clear_inputs(); bus.ItStartE = 1; bus.CondE = C_EQ; bus.ItLenE = 3; bus.ItMaskE = 4'b0111;
    step();
    clear_inputs(); bus.RegWriteE = 1;
    step();
    for (int s = 0; s < 3; s++) begin
      clear_inputs(); bus.stall = 1; bus.RegWriteE = 1; bus.MemWriteE = 1; bus.BranchE = 1;
      bus.FlagWriteE = 2'b11; bus.ALUFlagsE = 4'b1011;
      step();
      chk("stall_strobes", 64'(samp_strobes), 64'(0));
      chk("stall_count",   64'(bus.ItCount),  64'(2));
      chk("stall_flags",   64'(bus.Flags),    64'(4'b0100));
      $display("stall cycle %0d count=%0d strobes=%h", s, bus.ItCount, samp_strobes);
    end
    clear_inputs(); bus.flush = 1; bus.RegWriteE = 1;
    step();
    chk("flush_count", 64'(bus.ItCount), 64'(0));
    chk("flush_flags", 64'(bus.Flags),   64'(4'b0100));

    // Asynchronous reset in the middle of an open block.
    clear_inputs(); bus.ItStartE = 1; bus.CondE = C_EQ; bus.ItLenE = 3; bus.ItMaskE = 4'b0111;
    step();
    clear_inputs(); bus.RegWriteE = 1;
    step();
    chk("prereset_count", 64'(bus.ItCount), 64'(2));
    clear_inputs(); bus.RegWriteE = 1;
    #2;
    reset = 0;
    #1;
    model_reset();
    chk("areset_count",    64'(bus.ItCount),  64'(0));
    chk("areset_active",   64'(bus.ItActive), 64'(0));
    chk("areset_flags",    64'(bus.Flags),    64'(0));
    chk("areset_flagsv",   64'(bus.FlagsV),   64'(0));
    chk("areset_regwrite", 64'(bus.RegWrite), 64'(0));
    $display("async reset count=%0d flags=%h", bus.ItCount, bus.Flags);
    @(posedge clk);
    #1;
    reset = 1;

    // Randomized run against the queue model.
    for (int n = 0; n < 3000; n++) begin
      bus.ValidE      = ($urandom_range(0, 99) < 85);
      bus.stall       = ($urandom_range(0, 99) < 10);
      bus.flush       = ($urandom_range(0, 99) < 4);
      bus.CondE       = 4'($urandom);
      bus.FlagWriteE  = 2'($urandom);
      bus.ALUFlagsE   = 4'($urandom);
      bus.BranchE     = ($urandom_range(0, 99) < 10);
      bus.PCSrcE      = ($urandom_range(0, 99) < 5);
      bus.RegWriteE   = 1'($urandom);
      bus.MemWriteE   = 1'($urandom);
      bus.linkE       = 1'($urandom);
      bus.NoWrite     = ($urandom_range(0, 99) < 15);
      bus.VecE        = 1'($urandom);
      bus.ALUFlagsVE  = 16'($urandom);
      bus.FlagWriteVE = 1'($urandom);
      bus.RegWriteVE  = 1'($urandom);
      bus.MemWriteVE  = 1'($urandom);
      bus.ItStartE    = ($urandom_range(0, 99) < 15);
      bus.ItLenE      = CNT_W'($urandom_range(0, 7));
      bus.ItMaskE     = IT_MAX'($urandom);
      step();
      if (n % 500 == 0)
        $display("random %0d flags=%h count=%0d errors=%0d", n, bus.Flags, bus.ItCount, errors);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
